// File: rtl/sos_cascade_ctrl.sv
// Sequencer for a cascade of biquad (SOS) sections: launches enabled sections in order,
// chains each output into the next input, and flags overruns and hung sections.
module sos_cascade_ctrl #(
    parameter int unsigned N_STAGES  = 4,
    parameter int unsigned DATA_SIZE = 24,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          sample_trig_i,
    input  logic [DATA_SIZE-1:0]          data_in_i,
    input  logic [N_STAGES-1:0]           stage_en_i,
    output logic [N_STAGES-1:0]           stage_trig_o,
    input  logic [N_STAGES-1:0]           stage_done_i,
    input  logic [N_STAGES*DATA_SIZE-1:0] stage_dout_i,
    output logic [N_STAGES*DATA_SIZE-1:0] stage_din_o,
    output logic [DATA_SIZE-1:0]          data_out_o,
    output logic                          data_valid_o,
    output logic                          busy_o,
    output logic                          overrun_err_o,
    output logic                          timeout_err_o,
    output logic [2:0]                    err_stage_o,
    input  logic                          err_clr_i
);

    localparam int unsigned IdxW = 3;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [N_STAGES-1:0] OneHot0 = N_STAGES'(1);

    typedef enum logic [2:0] {StIdle, StLaunch, StWaitDone, StSettle, StDone} state_e;

    state_e                        state_q;
    logic [IdxW-1:0]               k_q;
    logic [N_STAGES-1:0]           en_q;
    logic [CntW-1:0]               cnt_q;
    logic [N_STAGES-1:0]           stage_trig_q;
    logic [N_STAGES*DATA_SIZE-1:0] stage_din_q;
    logic [DATA_SIZE-1:0]          data_out_q;
    logic                          data_valid_q;
    logic                          overrun_q;
    logic                          timeout_q;
    logic [IdxW-1:0]               err_stage_q;

    logic                 first_found;
    logic [IdxW-1:0]      first_idx;
    logic                 next_found;
    logic [IdxW-1:0]      next_idx;
    logic                 done_k;
    logic [DATA_SIZE-1:0] dout_k;

    // Lowest enabled section for a new sample, next enabled section above k, and
    // the handshake/data of the active section.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        done_k      = 1'b0;
        dout_k      = '0;
        for (int i = 0; i < int'(N_STAGES); i++) begin
            if (!first_found && stage_en_i[i]) begin
                first_found = 1'b1;
                first_idx   = IdxW'(i);
            end
            if (!next_found && en_q[i] && (IdxW'(i) > k_q)) begin
                next_found = 1'b1;
                next_idx   = IdxW'(i);
            end
            if (IdxW'(i) == k_q) begin
                done_k = stage_done_i[i];
                dout_k = stage_dout_i[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            k_q          <= '0;
            en_q         <= '0;
            cnt_q        <= '0;
            stage_trig_q <= '0;
            stage_din_q  <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            err_stage_q  <= '0;
        end else begin
            stage_trig_q <= '0;
            data_valid_q <= 1'b0;

            if (sample_trig_i && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end else if (err_clr_i) begin
                overrun_q <= 1'b0;
            end
            // A timeout raised below in the same cycle overrides this clear.
            if (err_clr_i) begin
                timeout_q   <= 1'b0;
                err_stage_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (sample_trig_i) begin
                        en_q <= stage_en_i;
                        if (first_found) begin
                            k_q          <= first_idx;
                            stage_trig_q <= OneHot0 << first_idx;
                            stage_din_q[first_idx*DATA_SIZE +: DATA_SIZE] <= data_in_i;
                            state_q      <= StLaunch;
                        end else begin
                            data_out_q   <= data_in_i;
                            data_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end
                    end
                end
                StLaunch: begin
                    cnt_q   <= '0;
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (done_k) begin
                        state_q <= StSettle;
                    end else if (cnt_q == CntLast) begin
                        timeout_q   <= 1'b1;
                        err_stage_q <= k_q;
                        state_q     <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (next_found) begin
                        k_q          <= next_idx;
                        stage_trig_q <= OneHot0 << next_idx;
                        stage_din_q[next_idx*DATA_SIZE +: DATA_SIZE] <= dout_k;
                        state_q      <= StLaunch;
                    end else begin
                        data_out_q   <= dout_k;
                        data_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stage_trig_o  = stage_trig_q;
    assign stage_din_o   = stage_din_q;
    assign data_out_o    = data_out_q;
    assign data_valid_o  = data_valid_q;
    assign busy_o        = (state_q != StIdle);
    assign overrun_err_o = overrun_q;
    assign timeout_err_o = timeout_q;
    assign err_stage_o   = err_stage_q;

endmodule

// File: tb/tb_sos_cascade_ctrl.sv
// Bench for sos_cascade_ctrl: behavioural section responders, a cascade reference model
// feeding expectation queues, and monitors that pop and compare on DUT activity.
module tb_sos_cascade_ctrl;

    localparam int N = 4;
    localparam int D = 24;
    localparam int T = 15;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             sample_trig = 1'b0;
    logic [D-1:0]     data_in = '0;
    logic [N-1:0]     stage_en = '0;
    logic [N-1:0]     stage_trig;
    logic [N-1:0]     stage_done = '0;
    logic [N*D-1:0]   stage_dout = '0;
    logic [N*D-1:0]   stage_din;
    logic [D-1:0]     data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun_err;
    logic             timeout_err;
    logic [2:0]       err_stage;
    logic             err_clr = 1'b0;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int stage; logic [D-1:0] din; int dly; bit hang; } trig_t;
    typedef struct { logic [D-1:0] data; int cyc; } res_t;
    trig_t tq[$];
    res_t  rq[$];

    sos_cascade_ctrl #(.N_STAGES(N), .DATA_SIZE(D), .TIMEOUT(T)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .sample_trig_i (sample_trig),
        .data_in_i     (data_in),
        .stage_en_i    (stage_en),
        .stage_trig_o  (stage_trig),
        .stage_done_i  (stage_done),
        .stage_dout_i  (stage_dout),
        .stage_din_o   (stage_din),
        .data_out_o    (data_out),
        .data_valid_o  (data_valid),
        .busy_o        (busy),
        .overrun_err_o (overrun_err),
        .timeout_err_o (timeout_err),
        .err_stage_o   (err_stage),
        .err_clr_i     (err_clr)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Section k transfer function; distinct per stage so ordering errors show up.
    function automatic logic [D-1:0] sec_f(input int k, input logic [D-1:0] x);
        logic [D-1:0] key;
        key = 24'h5A5A5A;
        return (x ^ (key >> k)) + D'(k + 1);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stage_trig"}, stage_trig, 0);
        chk({tag, "_stage_din"}, stage_din, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun_err, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
        chk({tag, "_err_stage"}, err_stage, 0);
    endtask

    // Reference model: fold the sample through enabled sections; each costs 4+delay
    // cycles, a hung section ends the sample after TIMEOUT waiting cycles.
    task automatic issue(input logic [N-1:0] en, input logic [D-1:0] din,
                         input logic [2*N-1:0] dly, input int hang, output int exp_c);
        logic [D-1:0] x;
        int p, t_cyc;
        bit hung;
        trig_t t;
        res_t r;
        x = din;
        p = cyc;
        t_cyc = 1;
        hung = 0;
        exp_c = 0;
        for (int k = 0; k < N; k++) begin
            if (en[k] && !hung) begin
                t.stage = k;
                t.din = x;
                t.dly = int'(dly[2*k +: 2]);
                t.hang = (k == hang);
                tq.push_back(t);
                if (k == hang) begin
                    hung = 1;
                    exp_c = p + t_cyc + T + 1;
                end else begin
                    x = sec_f(k, x);
                    t_cyc += 4 + t.dly;
                end
            end
        end
        if (!hung) begin
            r.data = x;
            r.cyc = p + t_cyc;
            rq.push_back(r);
            exp_c = r.cyc;
        end
        sample_trig = 1'b1;
        data_in = din;
        stage_en = en;
        tick();
        sample_trig = 1'b0;
        data_in = D'($urandom);
        stage_en = N'($urandom);
    endtask

    // Section responders: check each launch against the expected one, then answer.
    initial begin : responder
        int k;
        bit found;
        trig_t t;
        logic [N-1:0] nz;
        forever begin
            @(negedge clk);
            if (reset_n && stage_trig != '0) begin
                chk("trig_onehot", $onehot(stage_trig), 1);
                found = 0;
                k = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && stage_trig[i]) begin
                        found = 1;
                        k = i;
                    end
                end
                if (tq.size() == 0) begin
                    chk("unexpected_trig", stage_trig, 0);
                end else begin
                    t = tq.pop_front();
                    chk("trig_stage", k, t.stage);
                    chk("trig_din", stage_din[k*D +: D], t.din);
                    if (!t.hang) begin
                        nz = N'($urandom) & ~(N'(1) << k);
                        tick();
                        stage_done = nz;
                        for (int j = 0; j < t.dly; j++) begin
                            tick();
                            stage_done = N'($urandom) & ~(N'(1) << k);
                        end
                        tick();
                        stage_done = N'(1) << k;
                        stage_dout[k*D +: D] = sec_f(k, stage_din[k*D +: D]);
                        tick();
                        stage_done = '0;
                    end
                end
            end
        end
    end

    initial begin : result_monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_valid", data_valid, 0);
                end else begin
                    r = rq.pop_front();
                    chk("result_data", data_out, r.data);
                    chk("result_cycle", cyc, r.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int e, p;
        #1 reset_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Full cascade, then sparse enable, then pass-through.
        issue(4'hF, 24'h000100, '0, -1, e);
        wait_until(e + 1);
        issue(4'b1010, 24'h0ABCDE, '0, -1, e);
        wait_until(e + 1);
        issue(4'b0000, 24'h123456, '0, -1, e);
        wait_until(e + 1);

        // Sample arriving mid-cascade is dropped and flagged.
        p = cyc;
        issue(4'hF, 24'h0F00F0, '0, -1, e);
        wait_until(p + 5);
        chk("overrun_pre", overrun_err, 0);
        sample_trig = 1'b1;
        data_in = 24'h777777;
        tick();
        sample_trig = 1'b0;
        chk("overrun_set", overrun_err, 1);
        wait_until(e + 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("overrun_clr", overrun_err, 0);

        // Trigger during DONE is an overrun; the cycle after DONE accepts back-to-back.
        issue(4'b0000, 24'h00ABCD, '0, -1, e);
        sample_trig = 1'b1;
        tick();
        sample_trig = 1'b0;
        chk("overrun_in_done", overrun_err, 1);
        issue(4'b0000, 24'h654321, '0, -1, e);
        wait_until(e + 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("overrun_clr2", overrun_err, 0);

        // New overrun in the same cycle as err_clr keeps the flag set.
        issue(4'b0001, 24'h0000AA, '0, -1, e);
        sample_trig = 1'b1;
        err_clr = 1'b1;
        tick();
        sample_trig = 1'b0;
        err_clr = 1'b0;
        chk("err_wins", overrun_err, 1);
        wait_until(e + 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("overrun_clr3", overrun_err, 0);

        // Hung section 2 times out after TIMEOUT waiting cycles.
        issue(4'hF, 24'h001234, '0, 2, e);
        wait_until(e - 1);
        chk("to_busy_pre", busy, 1);
        chk("to_flag_pre", timeout_err, 0);
        tick();
        chk("to_flag", timeout_err, 1);
        chk("to_err_stage", err_stage, 2);
        chk("to_busy", busy, 0);
        repeat (3) tick();
        chk("to_err_stage_hold", err_stage, 2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", timeout_err, 0);
        chk("to_err_stage_clr", err_stage, 0);

        // Reset mid-cascade with an overrun pending; then a normal run.
        p = cyc;
        issue(4'hF, 24'h0C0FFE, '0, -1, e);
        wait_until(p + 3);
        sample_trig = 1'b1;
        tick();
        sample_trig = 1'b0;
        wait_until(p + 6);
        reset_n = 1'b0;
        #1 check_zero("midreset");
        tick();
        reset_n = 1'b1;
        tq.delete();
        rq.delete();
        repeat (6) tick();
        issue(4'hF, 24'h000100, '0, -1, e);
        wait_until(e + 1);

        // Randomized samples with random section latencies and gaps.
        for (int i = 0; i < 40; i++) begin
            issue(N'($urandom), D'($urandom), 8'($urandom), -1, e);
            wait_until(e + 1 + int'($urandom_range(0, 2)));
        end

        repeat (10) tick();
        chk("results_left", rq.size(), 0);
        chk("launches_left", tq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
